// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives the data-memory req/ack bus, steers store
// byte lanes, returns extended load data and stalls the pipeline while busy.
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [2:0]        mem_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] load_data,
   output logic              ale,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [3:0]        dm_wstrb,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t            state;
   size_t             size;
   logic [1:0]        off_q;
   logic [2:0]        op_q;
   logic              accept;
   logic              misaligned;
   logic [3:0]        wstrb_n;
   logic [DATA_W-1:0] wdata_n;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] ext_data;

   assign accept = (state == IDLE) && req_valid && (is_load || is_store);

   // Stall must rise in the accept cycle itself, so it cannot wait for a register.
   assign stall = !rst && ((state == REQ) || accept);

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      size    = SZ_W;
      wstrb_n = 4'b1111;
      wdata_n = store_data;
      case (mem_op)
         3'b000, 3'b100: begin
            size    = SZ_B;
            wstrb_n = 4'b0001 << addr[1:0];
            wdata_n = {4{store_data[7:0]}};
         end
         3'b001, 3'b101: begin
            size    = SZ_H;
            wstrb_n = addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{store_data[15:0]}};
         end
         default: ;
      endcase
      misaligned = ((size == SZ_H) && addr[0]) ||
                   ((size == SZ_W) && (addr[1:0] != 2'b00));
   end

   always_comb begin
      byte_sel = dm_rdata[8*off_q +: 8];
      half_sel = dm_rdata[16*off_q[1] +: 16];
      ext_data = dm_rdata;
      case (op_q)
         3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ext_data = {24'b0, byte_sel};
         3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  ext_data = {16'b0, half_sel};
         default: ext_data = dm_rdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         off_q      <= 2'b00;
         op_q       <= 3'b000;
         resp_valid <= 1'b0;
         ale        <= 1'b0;
         load_data  <= '0;
         dm_req     <= 1'b0;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_wstrb   <= 4'b0000;
         dm_wdata   <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  off_q <= addr[1:0];
                  op_q  <= mem_op;
                  if (misaligned) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     ale        <= 1'b1;
                     load_data  <= '0;
                  end else begin
                     state    <= REQ;
                     dm_req   <= 1'b1;
                     dm_we    <= !is_load;
                     dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
                     dm_wstrb <= is_load ? 4'b0000 : wstrb_n;
                     dm_wdata <= is_load ? '0 : wdata_n;
                  end
               end
            end
            REQ: begin
               if (dm_ack) begin
                  state      <= DONE;
                  dm_req     <= 1'b0;
                  resp_valid <= 1'b1;
                  ale        <= 1'b0;
                  if (!dm_we) load_data <= ext_data;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine of the LoongArch pipeline. Drives the data-memory request/acknowledge bus and performs store byte-lane steering.
- Returns aligned, sign/zero-extended load data. That data feeds the writeback memory-data input (WDSel = 3'b001).
- Stalls the pipeline while a memory access is outstanding and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data bus width; fixed at 32, other values unsupported

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  MEM stage holds a valid memory instruction
- is_load  input  1  instruction is a load
- is_store  input  1  instruction is a store
- mem_op  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address from the ALU
- store_data  input  32  rk/rd register value to be stored
- stall  output  1  freeze IF/ID/EX/MEM while high
- resp_valid  output  1  one-cycle pulse: access complete
- load_data  output  32  extended load result to writeback
- ale  output  1  address-misalignment flag; valid while resp_valid=1
- dm_req  output  1  data-memory request, held until dm_ack
- dm_we  output  1  1 = write
- dm_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- dm_wstrb  output  4  byte-write enables
- dm_wdata  output  32  lane-replicated write data
- dm_ack  input  1  memory acknowledges the request (one-cycle pulse)
- dm_rdata  input  32  read word; valid when dm_ack=1

Behaviour:
- Reset values: state IDLE; stall, resp_valid, ale, dm_req, dm_we = 0; dm_addr, dm_wdata, load_data = 0; dm_wstrb = 4'b0000.
- Reset is asynchronous. Asserting it mid-access forces IDLE and drops dm_req immediately.
- A dm_ack arriving after reset, or whenever the state is not REQ, is ignored.

State machine:
- States: IDLE, REQ, DONE.
- IDLE, request accepted when req_valid & (is_load | is_store):
  - stall = 1 combinationally in that cycle.
  - addr, mem_op, store_data and direction are captured.
  - Load takes priority if both is_load and is_store are set.
- IDLE, misaligned request (H/HU with addr[0]=1, or W with addr[1:0]!=0):
  - Next state DONE with ale=1 and load_data=0.
  - No bus access is made.
- IDLE, aligned request: next state REQ.
- REQ:
  - dm_req=1; dm_we, dm_addr, dm_wstrb and dm_wdata are registered and stable.
  - stall=1.
  - On dm_ack, go to DONE. For a load, capture the extended result into load_data.
- DONE:
  - resp_valid=1 and stall=0, so the pipeline advances this edge.
  - dm_req=0.
  - Next state IDLE unconditionally. req_valid seen in DONE is not re-accepted.
- Latency: accept in cycle 0, dm_req from cycle 1. Ack in cycle k gives DONE in cycle k+1. Minimum total 3 cycles, with stall high for cycles 0..k.
- load_data and ale hold their values until the next DONE. A store leaves load_data unchanged.

Store lane steering (o = addr[1:0]):
- B: wstrb = 4'b0001 << o; wdata = {4{store_data[7:0]}}.
- H: wstrb = 4'b0011 << (2*addr[1]); wdata = {2{store_data[15:0]}}.
- W: wstrb = 4'b1111; wdata = store_data.
- BU/HU on a store are treated as B/H.
- Loads drive dm_wstrb = 0 and dm_we = 0.

Load extraction:
- Byte = dm_rdata[8*o +: 8].
- Half = dm_rdata[16*addr[1] +: 16].
- B and H sign-extend; BU and HU zero-extend; W passes the word through.
- Unlisted mem_op codes (011, 110, 111) are treated as W.

Test Plan:
- Reset mid-REQ: assert rst while dm_req=1 → dm_req, stall = 0 at once. A subsequent dm_ack is ignored and resp_valid stays 0.
- Load: ld.b at addr 0x1003, dm_rdata=0x80FF_1234, ack at cycle 1 → DONE at cycle 2, load_data=0xFFFF_FF80, stall high for cycles 0–1.
- Load: ld.hu at 0x2002, dm_rdata=0xBEEF_0000, ack delayed to cycle 4 → dm_req held for cycles 1–4, load_data=0x0000_BEEF at cycle 5.
- Store: st.h at 0x3002 with data 0x1234_ABCD → dm_we=1, dm_wstrb=4'b1100, dm_wdata=0xABCD_ABCD, dm_addr=0x3000.
- Misaligned: ld.w at 0x4001 → no dm_req, DONE at cycle 1 with ale=1, resp_valid=1, load_data=0.
- Back-to-back: two st.b (0x10, 0x11), with req_valid held through DONE → first gets wstrb 0001. The second is accepted only in the following IDLE cycle and gets wstrb 0010.
